fb_window_reader: RTL and testbench

- Avalon-MM read initiator for the second port of the 160x120 8-bit frame-buffer RAM (19200 words, 15-bit address).
- Scans a rectangular window (x0, y0, w, h) in raster order and emits its pixels as a valid/ready stream with start-of-packet and end-of-packet flags.
- Feeds the zoom/scaler datapath.
- Never writes the RAM.

---
 rtl/fb_window_reader.sv | 208 ++++++++++++++++++++
 tb/tb_fb_window_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_window_reader.sv
// fb_window_reader: Avalon-MM read initiator that scans a rectangular window of the
// 160x120 8-bit frame buffer in raster order. It emits the window as a valid/ready
// pixel stream with start- and end-of-packet flags. The RAM is never written.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start                        one-cycle pulse; samples cfg_* when idle
//   cfg_x0, cfg_y0, cfg_w, cfg_h window origin and size
//   busy, done, cfg_err          status: scan in progress, scan finished, window rejected
//   mem_*                        RAM port-2 (registered address, unregistered read data)
//   px_data, px_valid, px_ready  pixel stream handshake
//   px_sop, px_eop               first/last pixel of the window, qualified by px_valid
module fb_window_reader #(
    parameter int unsigned FB_WIDTH  = 160,
    parameter int unsigned FB_HEIGHT = 120,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        cfg_x0,
    input  logic [6:0]        cfg_y0,
    input  logic [7:0]        cfg_w,
    input  logic [6:0]        cfg_h,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_sop,
    output logic              px_eop
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e              state_q;
    logic [7:0]          w_q, col_q;
    logic [6:0]          h_q, row_q;
    logic [ADDR_W-1:0]   row_base_q;
    logic                busy_q, done_q, cfg_err_q;

    // Read issued last cycle; its data is on mem_readdata this cycle.
    logic                pend_q, pend_sop_q, pend_eop_q;

    // Two-entry FIFO: the head entry drives the stream outputs directly.
    logic                head_valid_q, head_sop_q, head_eop_q;
    logic [DATA_W-1:0]   head_data_q;
    logic                skid_valid_q, skid_sop_q, skid_eop_q;
    logic [DATA_W-1:0]   skid_data_q;

    logic                win_ok;
    logic [ADDR_W-1:0]   start_base;
    logic                pop, push, credit, issue;
    logic [1:0]          load;
    logic                last_col, last_row, last_rd, first_rd;

    always_comb begin
        win_ok = (cfg_w != 8'd0) && (cfg_h != 7'd0)
              && (({1'b0, cfg_x0} + {1'b0, cfg_w}) <= 9'(FB_WIDTH))
              && (({1'b0, cfg_y0} + {1'b0, cfg_h}) <= 8'(FB_HEIGHT));
        start_base = ADDR_W'(cfg_y0) * ADDR_W'(FB_WIDTH) + ADDR_W'(cfg_x0);

        pop  = head_valid_q & px_ready;
        push = pend_q;
        // Entries held or in flight; a pop this cycle frees a slot for the new read,
        // which keeps one pixel per clock with only two entries of buffering.
        load   = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(pend_q);
        credit = (load - 2'(pop)) < 2'd2;
        issue  = (state_q == StRead) && credit;

        last_col = (col_q == w_q - 8'd1);
        last_row = (row_q == h_q - 7'd1);
        last_rd  = last_col && last_row;
        first_rd = (col_q == 8'd0) && (row_q == 7'd0);

        mem_chipselect = issue;
        mem_address    = issue ? (row_base_q + ADDR_W'(col_q)) : '0;
    end

    assign mem_write     = 1'b0;
    assign mem_writedata = '0;
    assign mem_clken     = 1'b1;

    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign px_data  = head_data_q;
    assign px_valid = head_valid_q;
    assign px_sop   = head_sop_q;
    assign px_eop   = head_eop_q;

    // Control FSM and address counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            w_q        <= 8'd0;
            h_q        <= 7'd0;
            col_q      <= 8'd0;
            row_q      <= 7'd0;
            row_base_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_sop_q <= 1'b0;
            pend_eop_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            pend_q     <= issue;
            pend_sop_q <= issue && first_rd;
            pend_eop_q <= issue && last_rd;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (win_ok) begin
                            w_q        <= cfg_w;
                            h_q        <= cfg_h;
                            col_q      <= 8'd0;
                            row_q      <= 7'd0;
                            row_base_q <= start_base;
                            busy_q     <= 1'b1;
                            state_q    <= StRead;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (issue) begin
                        if (last_col) begin
                            col_q <= 8'd0;
                            if (last_row) begin
                                state_q <= StDrain;
                            end else begin
                                row_q      <= row_q + 7'd1;
                                row_base_q <= row_base_q + ADDR_W'(FB_WIDTH);
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                StDrain: begin
                    // The eop pixel is the last one in flight, so its acceptance
                    // means the FIFO is empty and no read is outstanding.
                    if (pop && head_eop_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output FIFO. Credit guarantees load never exceeds two, so a push into a full
    // FIFO cannot happen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
            head_sop_q   <= 1'b0;
            head_eop_q   <= 1'b0;
            head_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_sop_q   <= 1'b0;
            skid_eop_q   <= 1'b0;
            skid_data_q  <= '0;
        end else if (head_valid_q && !pop) begin
            // Head stalled: hold it; park any returning pixel behind it.
            if (!skid_valid_q && push) begin
                skid_valid_q <= 1'b1;
                skid_sop_q   <= pend_sop_q;
                skid_eop_q   <= pend_eop_q;
                skid_data_q  <= mem_readdata;
            end
        end else if (skid_valid_q) begin
            head_valid_q <= 1'b1;
            head_sop_q   <= skid_sop_q;
            head_eop_q   <= skid_eop_q;
            head_data_q  <= skid_data_q;
            skid_valid_q <= push;
            if (push) begin
                skid_sop_q  <= pend_sop_q;
                skid_eop_q  <= pend_eop_q;
                skid_data_q <= mem_readdata;
            end
        end else if (push) begin
            head_valid_q <= 1'b1;
            head_sop_q   <= pend_sop_q;
            head_eop_q   <= pend_eop_q;
            head_data_q  <= mem_readdata;
        end else begin
            // Data and flags keep their last value once the beat is gone.
            head_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_window_reader.sv
module tb_fb_window_reader;

    localparam int FBW  = 160;
    localparam int FBH  = 120;
    localparam int NPIX = FBW * FBH;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  cfg_x0, cfg_w;
    logic [6:0]  cfg_y0, cfg_h;
    logic        busy, done, cfg_err;
    logic [14:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [7:0]  mem_writedata, mem_readdata;
    logic [7:0]  px_data;
    logic        px_valid, px_ready, px_sop, px_eop;

    fb_window_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .cfg_x0         (cfg_x0),
        .cfg_y0         (cfg_y0),
        .cfg_w          (cfg_w),
        .cfg_h          (cfg_h),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .px_data        (px_data),
        .px_valid       (px_valid),
        .px_ready       (px_ready),
        .px_sop         (px_sop),
        .px_eop         (px_eop)
    );

    always #5 clk = ~clk;

    // Frame-buffer RAM model: registered address, data out one cycle after the read.
    logic [7:0] mem [NPIX];
    logic [7:0] rd_q = 8'd0;
    always @(posedge clk) begin
        if (mem_chipselect && int'(mem_address) < NPIX) rd_q <= mem[int'(mem_address)];
    end
    assign mem_readdata = rd_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    typedef struct {
        int         addr;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    // mode: 0 = ready held high, 1 = ready pattern 1,0,0,1, 2 = random ready.
    // restart_at: cycle at which a valid start is pulsed mid-scan (-1 = never).
    task automatic run_scan(input int x0, input int y0, input int w, input int h,
                            input int mode, input int restart_at, input int budget);
        beat_t exp_rd[$];
        beat_t exp_px[$];
        beat_t b;
        int issued = 0;
        int accepted = 0;
        int eop_cyc = -1;
        bit seen_done = 1'b0;
        bit stall_prev = 1'b0;
        logic [7:0] pd = 8'd0;
        logic ps = 1'b0;
        logic pe = 1'b0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                b.addr = (y0 + r) * FBW + x0 + c;
                b.data = mem[b.addr];
                b.sop  = (r == 0) && (c == 0);
                b.eop  = (r == h - 1) && (c == w - 1);
                exp_rd.push_back(b);
                exp_px.push_back(b);
            end
        end
        @(posedge clk); #1;
        cfg_x0 = 8'(x0); cfg_y0 = 7'(y0); cfg_w = 8'(w); cfg_h = 7'(h);
        start = 1'b1;
        for (int cyc = 0; cyc < budget && !seen_done; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                cfg_x0 = 8'd0; cfg_y0 = 7'd0; cfg_w = 8'd1; cfg_h = 7'd1;
            end else begin
                cfg_x0 = 8'($urandom); cfg_y0 = 7'($urandom);
                cfg_w = 8'($urandom); cfg_h = 7'($urandom);
            end
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: px_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (stall_prev) begin
                check("stall_valid", 32'(px_valid), 32'd1);
                check("stall_data", 32'(px_data), 32'(pd));
                check("stall_sop", 32'(px_sop), 32'(ps));
                check("stall_eop", 32'(px_eop), 32'(pe));
            end
            if (mem_chipselect) begin
                issued++;
                if (exp_rd.size() > 0) begin
                    b = exp_rd.pop_front();
                    check("rd_addr", 32'(mem_address), 32'(b.addr));
                end else begin
                    check("rd_count", 32'(issued), 32'(w * h));
                end
            end
            if (px_valid && px_ready) begin
                accepted++;
                if (exp_px.size() > 0) begin
                    b = exp_px.pop_front();
                    check("px_data", 32'(px_data), 32'(b.data));
                    check("px_sop", 32'(px_sop), 32'(b.sop));
                    check("px_eop", 32'(px_eop), 32'(b.eop));
                end else begin
                    check("px_count", 32'(accepted), 32'(w * h));
                end
                if (px_eop) eop_cyc = cyc;
            end
            check("rd_ahead", 32'((issued - accepted) <= 2), 32'd1);
            stall_prev = px_valid && !px_ready;
            pd = px_data; ps = px_sop; pe = px_eop;
            if (done) begin
                seen_done = 1'b1;
                check("done_latency", 32'(cyc), 32'(eop_cyc + 1));
                check("busy_at_done", 32'(busy), 32'd0);
            end else begin
                check("busy", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        check("done_seen", 32'(seen_done), 32'd1);
        check("beats", 32'(accepted), 32'(w * h));
        check("reads", 32'(issued), 32'(w * h));
    endtask

    task automatic check_invalid(input int x0, input int y0, input int w, input int h);
        @(posedge clk); #1;
        cfg_x0 = 8'(x0); cfg_y0 = 7'(y0); cfg_w = 8'(w); cfg_h = 7'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        check("inv_busy", 32'(busy), 32'd0);
        check("inv_cs", 32'(mem_chipselect), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cfg_err_clear", 32'(cfg_err), 32'd0);
            check("inv_busy", 32'(busy), 32'd0);
            check("inv_cs", 32'(mem_chipselect), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_px_valid"}, 32'(px_valid), 32'd0);
        check({tag, "_px_sop"}, 32'(px_sop), 32'd0);
        check({tag, "_px_eop"}, 32'(px_eop), 32'd0);
        check({tag, "_px_data"}, 32'(px_data), 32'd0);
        check({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), 32'd0);
    endtask

    initial begin
        int x0, y0, w, h;
        bit hit;
        reset_n  = 1'b0;
        start    = 1'b0;
        px_ready = 1'b0;
        cfg_x0 = 8'd0; cfg_y0 = 7'd0; cfg_w = 8'd0; cfg_h = 7'd0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("mem_write", 32'(mem_write), 32'd0);
        check("mem_writedata", 32'(mem_writedata), 32'd0);
        check("mem_clken", 32'(mem_clken), 32'd1);
        #2 reset_n = 1'b1;

        // Full frame, data = addr[7:0].
        run_scan(0, 0, FBW, FBH, 0, -1, NPIX + 50);

        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);

        // Small window, then with backpressure.
        run_scan(10, 5, 3, 2, 0, -1, 100);
        run_scan(10, 5, 3, 2, 1, -1, 200);

        // Invalid windows.
        check_invalid(150, 0, 11, 1);
        check_invalid(0, 0, 1, 0);
        check_invalid(0, 100, 1, 21);
        check_invalid(5, 5, 0, 3);

        // Minimal window at the last address, with a start pulsed while busy.
        run_scan(159, 119, 1, 1, 0, 1, 50);
        run_scan(10, 5, 3, 2, 2, 1, 200);

        // Random windows with random backpressure.
        for (int k = 0; k < 8; k++) begin
            x0 = $urandom_range(0, FBW - 1);
            y0 = $urandom_range(0, FBH - 1);
            w  = $urandom_range(1, (FBW - x0 < 24) ? FBW - x0 : 24);
            h  = $urandom_range(1, (FBH - y0 < 6) ? FBH - y0 : 6);
            run_scan(x0, y0, w, h, 2, -1, w * h * 6 + 40);
        end

        // Reset mid-scan of a full frame with a read outstanding.
        @(posedge clk); #1;
        cfg_x0 = 8'd0; cfg_y0 = 7'd0; cfg_w = 8'd160; cfg_h = 7'd120;
        px_ready = 1'b1;
        start = 1'b1;
        hit = 1'b0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (cyc >= 50 && mem_chipselect) hit = 1'b1;
        end
        check("mid_scan_read", 32'(hit), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(px_valid), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_cs", 32'(mem_chipselect), 32'd0);
        end
        run_scan(20, 30, 7, 4, 2, -1, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
